// File: rtl/simplez_uart_tx.sv
// SIMPLEZ memory-mapped 8N1 transmitter: ST to ADDR_DATA starts a frame, status word at ADDR_STAT.
// A frame takes 10*BAUD_DIV falling edges; writes while busy are dropped and flagged as overrun.
module simplez_uart_tx #(
   parameter int                DATAW     = 12,
   parameter int                ADDRW     = 9,
   parameter logic [ADDRW-1:0]  ADDR_DATA = 9'o101,
   parameter logic [ADDRW-1:0]  ADDR_STAT = 9'o102,
   parameter int                BAUD_DIV  = 104
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [ADDRW-1:0] addr,
   input  logic             wr,
   input  logic             rd,
   input  logic [DATAW-1:0] data_in,
   output logic [DATAW-1:0] data_out,
   output logic             tx,
   output logic             busy
);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);

   state_t      r_state;
   logic [11:0] r_baud;
   logic [2:0]  r_bit;
   logic [7:0]  r_shift;
   logic        r_tx;
   logic        r_busy;
   logic        r_ovr;

   logic w_sel_data;
   logic w_sel_stat;
   logic w_wr_data;
   logic w_rd_stat;
   logic w_bit_end;
   logic w_unused;

   assign w_sel_data = (addr == ADDR_DATA);
   assign w_sel_stat = (addr == ADDR_STAT);
   assign w_wr_data  = wr & w_sel_data;
   assign w_rd_stat  = rd & w_sel_stat;
   assign w_bit_end  = (r_baud == BAUD_LAST);
   assign w_unused   = ^data_in[DATAW-1:8];

   // Status is decoded from registered state only, so it never follows wr.
   assign data_out = w_sel_stat ? {{(DATAW-3){1'b0}}, r_ovr, r_busy, ~r_busy} : '0;
   assign tx       = r_tx;
   assign busy     = r_busy;

   always_ff @(negedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= S_IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         // Setting takes priority over the read-to-clear.
         if (w_wr_data && (r_state != S_IDLE))
            r_ovr <= 1'b1;
         else if (w_rd_stat)
            r_ovr <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (w_wr_data) begin
                  r_shift <= data_in[7:0];
                  r_baud  <= '0;
                  r_bit   <= '0;
                  r_tx    <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= S_START;
               end
            end
            S_START: begin
               if (w_bit_end) begin
                  r_baud  <= '0;
                  r_tx    <= r_shift[0];
                  r_state <= S_DATA;
               end else begin
                  r_baud <= r_baud + 12'd1;
               end
            end
            S_DATA: begin
               if (w_bit_end) begin
                  r_baud  <= '0;
                  r_shift <= r_shift >> 1;
                  r_bit   <= r_bit + 3'd1;
                  if (r_bit == 3'd7) begin
                     r_tx    <= 1'b1;
                     r_state <= S_STOP;
                  end else begin
                     r_tx <= r_shift[1];
                  end
               end else begin
                  r_baud <= r_baud + 12'd1;
               end
            end
            S_STOP: begin
               if (w_bit_end) begin
                  r_baud  <= '0;
                  r_tx    <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_baud <= r_baud + 12'd1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_tx    <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
